// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready,
// flush, bubble gating of control bits and an optional skid entry.
module pipe_stage_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 69,
  parameter bit SKID   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    SKID_FULL = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic in_fire, out_fire;
  logic load_in, load_skid, pop_skid;

  // With a skid entry, ready depends on state only; without it,
  // a full stage may accept only while downstream drains.
  assign in_ready  = SKID ? (state_q != SKID_FULL)
                          : ((state_q == EMPTY) | out_ready);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Bubbles must never carry live control bits downstream.
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state_q;

  // Next-state and storage load selects; flush drops everything.
  always_comb begin
    state_d   = state_q;
    load_in   = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = FULL;
            load_in = 1'b1;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            load_in = 1'b1;
          end else if (in_fire) begin
            if (SKID) begin
              state_d   = SKID_FULL;
              load_skid = 1'b1;
            end
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            state_d  = FULL;
            pop_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register; reset wins over flush.
  always_ff @(posedge clock) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Entry storage; payload is left stale on flush, zeroed on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (pop_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives SKID=1 and SKID=0 instances with shared
// stimulus and compares both against a small FIFO model.
module tb_pipe_stage_reg;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [2:0]  in_ctrl;
  logic [68:0] in_data;
  logic        out_ready;

  logic        a_in_ready, a_out_valid;
  logic [2:0]  a_out_ctrl;
  logic [68:0] a_out_data;
  logic [1:0]  a_occ;

  logic        b_in_ready, b_out_valid;
  logic [2:0]  b_out_ctrl;
  logic [68:0] b_out_data;
  logic [1:0]  b_occ;

  int n_checks = 0;
  int n_fail   = 0;

  // model: up to two FIFO entries per instance (0 = skid, 1 = no skid)
  logic [2:0]  m_ctrl [2][2];
  logic [68:0] m_data [2][2];
  int          cnt    [2];
  logic [68:0] stale  [2];
  bit          known = 1'b0;

  pipe_stage_reg #(.CTRL_W(3), .DATA_W(69), .SKID(1'b1)) u_skid (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.CTRL_W(3), .DATA_W(69), .SKID(1'b0)) u_noskid (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [95:0] got,
                     input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic bit exp_ready(input int k, input bit ordy);
    if (k == 0) return cnt[0] < 2;
    return (cnt[1] == 0) || ordy;
  endfunction

  task automatic check_all(input bit ordy);
    logic        rdy, ov;
    logic [2:0]  oc;
    logic [68:0] od;
    logic [1:0]  occ;
    string       nm;
    for (int k = 0; k < 2; k++) begin
      nm  = (k == 0) ? "skid" : "noskid";
      rdy = (k == 0) ? a_in_ready  : b_in_ready;
      ov  = (k == 0) ? a_out_valid : b_out_valid;
      oc  = (k == 0) ? a_out_ctrl  : b_out_ctrl;
      od  = (k == 0) ? a_out_data  : b_out_data;
      occ = (k == 0) ? a_occ       : b_occ;
      chk({nm, "_in_ready"}, 96'(rdy), 96'(exp_ready(k, ordy)));
      chk({nm, "_out_valid"}, 96'(ov), 96'(cnt[k] > 0));
      chk({nm, "_out_ctrl"}, 96'(oc),
          96'((cnt[k] > 0) ? m_ctrl[k][0] : 3'b000));
      chk({nm, "_out_data"}, 96'(od),
          96'((cnt[k] > 0) ? m_data[k][0] : stale[k]));
      chk({nm, "_occupancy"}, 96'(occ), 96'(cnt[k]));
    end
  endtask

  task automatic cycle(input bit rst, input bit fl, input bit iv,
                       input logic [2:0] c, input logic [68:0] d,
                       input bit ordy);
    bit ir, inf, outf;
    @(negedge clock);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (known) check_all(ordy);
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnt[k]   = 0;
        stale[k] = '0;
      end else if (fl) begin
        cnt[k] = 0;
      end else begin
        ir   = exp_ready(k, ordy);
        inf  = iv && ir;
        outf = (cnt[k] > 0) && ordy;
        if (outf) begin
          m_ctrl[k][0] = m_ctrl[k][1];
          m_data[k][0] = m_data[k][1];
          cnt[k]--;
        end
        if (inf) begin
          m_ctrl[k][cnt[k]] = c;
          m_data[k][cnt[k]] = d;
          cnt[k]++;
        end
        if (cnt[k] > 0) stale[k] = m_data[k][0];
      end
    end
    if (rst) known = 1'b1;
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 1'b0, 1'b0, 3'b000, 69'h0, ordy);
  endtask

  initial begin
    logic [95:0] r;
    bit          rst, fl, iv, ordy;
    cnt[0]    = 0;
    cnt[1]    = 0;
    stale[0]  = '0;
    stale[1]  = '0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // reset two cycles, then pass-through
    cycle(1'b1, 1'b0, 1'b0, 3'b000, 69'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 3'b000, 69'h0, 1'b1);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b0, 1'b1, 3'b101, 69'(8'h11 + i), 1'b1);
    idle(1'b1);
    idle(1'b1);

    // skid fill / no-skid stall, then drain
    cycle(1'b0, 1'b0, 1'b1, 3'b011, 69'hA, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 3'b010, 69'hB, 1'b0);
    idle(1'b0);
    cycle(1'b0, 1'b0, 1'b1, 3'b110, 69'hC, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // flush with simultaneous input while two deep
    cycle(1'b0, 1'b0, 1'b1, 3'b001, 69'h21, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 3'b001, 69'h22, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 3'b111, 69'h99, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // bubble gating after a ctrl=111 entry drains
    cycle(1'b0, 1'b0, 1'b1, 3'b111, 69'h5A, 1'b1);
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);

    // reset and flush together while full
    cycle(1'b0, 1'b0, 1'b1, 3'b101, 69'h77, 1'b0);
    idle(1'b0);
    cycle(1'b1, 1'b1, 1'b0, 3'b000, 69'h0, 1'b0);
    idle(1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r    = {$urandom, $urandom, $urandom};
      rst  = ($urandom_range(0, 63) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      cycle(rst, fl, iv, 3'($urandom), r[68:0], ordy);
    end
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the pipelined CPU, the generalised successor to the fixed-width stage registers. It carries a control field and a data payload, both of configurable width, from one stage to the next. It adds a valid/ready handshake, a synchronous flush for branch/exception squash, and an optional skid entry that registers the upstream ready path. Control bits leave the block forced to zero whenever the output is not valid, so a bubble can never write the register file or memory.

## Interface
- CTRL_W, 3: control-bit width (e.g. wreg, m2reg, wmem)
- DATA_W, 69: payload width (e.g. alu 32 + b 32 + rn 5)
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- clock  in  1  rising-edge clock; sole clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  block accepts an entry this cycle
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control bits; all zero when out_valid=0
- out_data  out  DATA_W  payload of the head entry
- occupancy  out  2  number of held entries (0..2)

## Operation
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs). The skid entry is present only if SKID=1.
- States: EMPTY (occ 0), FULL (occ 1), SKID_FULL (occ 2, SKID=1 only).
- EMPTY: in_fire -> FULL, main <= in.
- FULL, in_fire & out_fire -> FULL, main <= in.
- FULL, in_fire & !out_fire -> SKID_FULL, skid <= in. This transition exists only when SKID=1.
- FULL, !in_fire & out_fire -> EMPTY.
- SKID_FULL: out_fire -> FULL, main <= skid. in_fire is impossible in this state.
- in_ready:
  - SKID=1: in_ready = (state != SKID_FULL). It is a function of state only, with no combinational path from out_ready.
  - SKID=0: in_ready = (state==EMPTY) | out_ready. FULL with in_fire & !out_fire cannot occur.
- Order is strictly FIFO. No entry is dropped or duplicated except by flush or reset.
- out_valid = (state != EMPTY).
- out_ctrl = out_valid ? main_ctrl : 0.
- out_data shows the main payload regardless of valid. It holds its value while stalled (out_valid & !out_ready).
- Flush: next state is EMPTY. Any in_fire in the flush cycle is discarded. Payload registers keep stale data; only state and valid are cleared.
- Reset (priority over flush): next state is EMPTY, all storage zeroed.
- Holding stable: while out_valid & !out_ready, out_ctrl and out_data are unchanged.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0. in_ready=1 in both SKID modes.
- Latency: 1 cycle. An entry accepted at edge N is on the outputs after edge N.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- SKID=1: one extra entry is absorbed when downstream stalls. in_ready deasserts the cycle after the skid entry fills, and reasserts the cycle after the first out_fire in SKID_FULL.
- Flush or reset asserted at edge N: out_valid=0 and out_ctrl=0 after edge N. in_ready=1 after edge N.
- Reset mid-transfer: both entries are lost and occupancy returns to 0.

## Test plan
- Reset, then pass-through, SKID=1:
  - Hold reset 2 cycles: out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
  - Then send 4 entries with data 0x11..0x14, ctrl 3'b101, out_ready=1.
  - Required: each appears 1 cycle after acceptance, in order, with no gaps.
- Skid fill, SKID=1:
  - With FULL holding A, drop out_ready and present B.
  - Required: B is accepted, occupancy=2, in_ready=0 next cycle.
  - Raise out_ready: A then B are output on consecutive cycles, and in_ready=1 after A leaves.
- Stall, SKID=0:
  - FULL holding A, out_ready=0, in_valid=1.
  - Required: in_ready=0 combinationally and A is held.
  - With out_ready=1 in the same cycle, in_ready=1 and C replaces A after the edge.
- Flush with simultaneous input:
  - occupancy=2, assert flush with in_valid=1 data 0x99.
  - Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0x99 never appears.
- Bubble gating:
  - Idle after an entry with ctrl 3'b111 drains.
  - Required: out_ctrl=3'b000 whenever out_valid=0, while out_data may hold stale data.
- Reset vs flush priority:
  - Assert reset and flush together while FULL.
  - Required: out_data=0, not stale data, and occupancy=0.
